// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; the default build uses a registered output.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fifo_counter,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AFULL_C  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_C = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              empty_w;
  logic              full_w;
  logic              wr_acc;
  logic              rd_acc;

  assign wr_addr = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr = rd_ptr_q[ADDR_W-1:0];

  // The wrap bit distinguishes full from empty when the addresses coincide.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign wr_acc = write_en && !full_w;
  assign rd_acc = read_en && !empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  // A new error in the same cycle as err_clr wins, so the flag stays set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write_en && full_w) overflow_d  = 1'b1;
    if (read_en && empty_w) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_addr] <= buf_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign buf_out = mem_q[rd_addr];
`else
  logic [DATA_W-1:0] buf_out_q, buf_out_d;

  always_comb begin
    buf_out_d = buf_out_q;
    if (rd_acc) buf_out_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) buf_out_q <= '0;
    else      buf_out_q <= buf_out_d;
  end

  assign buf_out = buf_out_q;
`endif

  assign buf_empty    = empty_w;
  assign buf_full     = full_w;
  assign almost_empty = (count_q <= AEMPTY_C);
  assign almost_full  = (count_q >= AFULL_C);
  assign fifo_counter = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
